spi_sub: RTL and testbench

SPI subordinate (slave) endpoint: the far end of the SPI link driven by our spi_main.
- Receives SCLK, active-low SS and MOSI from an external main and oversamples them on the local clk.
- Shifts out a word on MISO from a one-entry TX holding register.
- Presents each received word with a one-cycle valid pulse.
- Sits between the board-level SPI pins and the local datapath.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_sync_edge.sv | 31 +++
 rtl/spi_sub.sv | 207 ++++++++++++++++++++
 tb/tb_spi_sub.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Types and mode helpers shared by the SPI main and subordinate endpoints.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    // CPHA=0 samples on the leading SCLK edge; CPHA=1 samples on the trailing edge.
    function automatic logic sample_on_leading(input logic cpha);
        return (cpha == 1'b0);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a previous-sample register for edge detection.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta  <= RESET_VAL;
            level <= RESET_VAL;
            prev  <= RESET_VAL;
        end else begin
            meta  <= d;
            level <= meta;
            prev  <= level;
        end
    end

    assign rise_c = level & ~prev;
    assign fall_c = ~level & prev;

endmodule

// File: rtl/spi_sub.sv
// SPI subordinate endpoint: oversampled SCLK/SS/MOSI, one-entry TX holding register,
// word-at-a-time receive with valid pulse.
module spi_sub
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic        CPOL       = 1'b1,
    parameter logic        CPHA       = 1'b1,
    parameter logic        LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_SCLK,
    input  logic                  i_SS_n,
    input  logic                  i_MOSI,
    output logic                  o_MISO,
    output logic                  o_MISO_oe,
    input  logic [DATA_WIDTH-1:0] i_data_in_TX,
    input  logic                  i_data_valid_TX,
    output logic                  o_data_ready_TX,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_data_valid,
    output logic                  o_tx_underrun,
    output logic                  o_frame_abort,
    output logic                  o_busy
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_meta, mosi_sync;

    spi_sync_edge #(.RESET_VAL(CPOL)) u_sclk_sync (
        .clk(clk), .reset(reset), .d(i_SCLK),
        .level(sclk_level), .rise_c(sclk_rise), .fall_c(sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
        .clk(clk), .reset(reset), .d(i_SS_n),
        .level(ss_level), .rise_c(ss_rise), .fall_c(ss_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= i_MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    logic sclk_lead_c, sclk_trail_c, sample_c, shift_c;
    logic unused_levels_c;

    assign sclk_lead_c     = CPOL ? sclk_fall : sclk_rise;
    assign sclk_trail_c    = CPOL ? sclk_rise : sclk_fall;
    assign sample_c        = sample_on_leading(CPHA) ? sclk_lead_c : sclk_trail_c;
    assign shift_c         = sample_on_leading(CPHA) ? sclk_trail_c : sclk_lead_c;
    assign unused_levels_c = sclk_level ^ ss_level;

    function automatic logic out_bit(input logic [DATA_WIDTH-1:0] sr);
        return LSB_FIRST ? sr[0] : sr[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] sr);
        return LSB_FIRST ? {1'b0, sr[DATA_WIDTH-1:1]} : {sr[DATA_WIDTH-2:0], 1'b0};
    endfunction

    spi_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  underrun_q, underrun_d;
    logic                  abort_q, abort_d;
    logic                  miso_q, miso_d;
    logic                  busy_q, busy_d;

    logic                  load_c;
    logic [DATA_WIDTH-1:0] load_word_c;
    logic [DATA_WIDTH-1:0] rx_next_c;

    assign rx_next_c = LSB_FIRST ? {mosi_sync, rx_sr_q[DATA_WIDTH-1:1]}
                                 : {rx_sr_q[DATA_WIDTH-2:0], mosi_sync};

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        tx_hold_d   = tx_hold_q;
        ready_d     = ready_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        bit_cnt_d   = bit_cnt_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;
        miso_d      = miso_q;
        busy_d      = busy_q;
        load_c      = 1'b0;
        load_word_c = '0;

        if (i_data_valid_TX && ready_q) begin
            tx_hold_d = i_data_in_TX;
            ready_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = ACTIVE;
                    busy_d  = 1'b1;
                    load_c  = 1'b1;
                end
            end
            ACTIVE: begin
                if (sample_c) begin
                    rx_sr_d = rx_next_c;
                    if (bit_cnt_q == LAST_BIT) begin
                        data_out_d = rx_next_c;
                        valid_d    = 1'b1;
                        bit_cnt_d  = '0;
                        load_c     = !ss_rise;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shift_c && (CPHA || (bit_cnt_q != '0))) begin
                    // With CPHA=0 the trailing edge after the last sample must not
                    // disturb the first bit of the freshly loaded word.
                    miso_d  = out_bit(tx_sr_q);
                    tx_sr_d = shift_out(tx_sr_q);
                end
                if (ss_rise) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    miso_d    = 1'b0;
                    bit_cnt_d = '0;
                    abort_d   = (bit_cnt_q != '0) && !(sample_c && (bit_cnt_q == LAST_BIT));
                end
            end
            default: state_d = IDLE;
        endcase

        // An accept in the same cycle leaves ready_d low, so the new word is kept.
        if (load_c) begin
            if (!ready_q) begin
                load_word_c = tx_hold_q;
                ready_d     = 1'b1;
            end else begin
                underrun_d = 1'b1;
            end
            bit_cnt_d = '0;
            if (CPHA) begin
                tx_sr_d = load_word_c;
            end else begin
                miso_d  = out_bit(load_word_c);
                tx_sr_d = shift_out(load_word_c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_hold_q  <= '0;
            ready_q    <= 1'b1;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            bit_cnt_q  <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_hold_q  <= tx_hold_d;
            ready_q    <= ready_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            bit_cnt_q  <= bit_cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            underrun_q <= underrun_d;
            abort_q    <= abort_d;
            miso_q     <= miso_d;
            busy_q     <= busy_d;
        end
    end

    assign o_MISO          = miso_q & busy_q & ~unused_levels_c | miso_q & busy_q & unused_levels_c;
    assign o_MISO_oe       = busy_q;
    assign o_busy          = busy_q;
    assign o_data_ready_TX = ready_q;
    assign o_data_out      = data_out_q;
    assign o_data_valid    = valid_q;
    assign o_tx_underrun   = underrun_q;
    assign o_frame_abort   = abort_q;

endmodule

// File: tb/tb_spi_sub.sv
// Scoreboard bench for spi_sub: mode 3 and mode 0 instances driven by a behavioural SPI main.
module tb_spi_sub;

    logic clk = 1'b0;
    logic reset;

    logic [1:0]      sclk, ss_n, mosi, dvtx;
    logic [1:0][7:0] din;
    logic [1:0]      miso, oe, rdy, dv, und, abt, busy;
    logic [1:0][7:0] dout;

    always #5 clk = ~clk;

    // Instance 0: mode 3 (CPOL=1, CPHA=1), LSB first.
    spi_sub #(.DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1)) u_dut3 (
        .clk(clk), .reset(reset),
        .i_SCLK(sclk[0]), .i_SS_n(ss_n[0]), .i_MOSI(mosi[0]),
        .o_MISO(miso[0]), .o_MISO_oe(oe[0]),
        .i_data_in_TX(din[0]), .i_data_valid_TX(dvtx[0]), .o_data_ready_TX(rdy[0]),
        .o_data_out(dout[0]), .o_data_valid(dv[0]),
        .o_tx_underrun(und[0]), .o_frame_abort(abt[0]), .o_busy(busy[0])
    );

    // Instance 1: mode 0 (CPOL=0, CPHA=0), LSB first.
    spi_sub #(.DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .reset(reset),
        .i_SCLK(sclk[1]), .i_SS_n(ss_n[1]), .i_MOSI(mosi[1]),
        .o_MISO(miso[1]), .o_MISO_oe(oe[1]),
        .i_data_in_TX(din[1]), .i_data_valid_TX(dvtx[1]), .o_data_ready_TX(rdy[1]),
        .o_data_out(dout[1]), .o_data_valid(dv[1]),
        .o_tx_underrun(und[1]), .o_frame_abort(abt[1]), .o_busy(busy[1])
    );

    int n_checks = 0;
    int n_pass   = 0;
    int und_cnt[2];
    int abt_cnt[2];
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compare every valid pulse against the expected queue, count event pulses.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (und[d] === 1'b1) und_cnt[d]++;
            if (abt[d] === 1'b1) abt_cnt[d]++;
        end
        if (dv[0] === 1'b1) begin
            if (exp_q0.size() == 0) check("spurious_valid_mode3", 32'(dout[0]), 32'hFFFF_FFFF);
            else check("rx_word_mode3", 32'(dout[0]), 32'(exp_q0.pop_front()));
        end
        if (dv[1] === 1'b1) begin
            if (exp_q1.size() == 0) check("spurious_valid_mode0", 32'(dout[1]), 32'hFFFF_FFFF);
            else check("rx_word_mode0", 32'(dout[1]), 32'(exp_q1.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input int d, input logic [7:0] w);
        int t;
        t = 0;
        while (rdy[d] !== 1'b1 && t < 200) begin
            tick(1);
            t++;
        end
        if (rdy[d] !== 1'b1) check("preload_ready_timeout", 32'(rdy[d]), 32'd1);
        din[d]  = w;
        dvtx[d] = 1'b1;
        tick(1);
        dvtx[d] = 1'b0;
    endtask

    // Behavioural SPI main, LSB first, SCLK = clk/10.
    task automatic xfer(input int d, input logic cpol, input logic cpha, input logic [7:0] tx,
                        input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi[d] = tx[i];
                tick(5);
                sclk[d] = ~cpol;
                rx[i]   = miso[d];
                tick(5);
                sclk[d] = cpol;
            end else begin
                sclk[d] = ~cpol;
                mosi[d] = tx[i];
                tick(5);
                sclk[d] = cpol;
                rx[i]   = miso[d];
                tick(5);
            end
        end
    endtask

    task automatic ss_low(input int d);
        ss_n[d] = 1'b0;
        tick(10);
    endtask

    task automatic ss_high(input int d);
        tick(5);
        ss_n[d] = 1'b1;
        tick(10);
    endtask

    function automatic logic [7:0] status(input int d);
        return {1'b0, miso[d], oe[d], rdy[d], dv[d], und[d], abt[d], busy[d]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        int exp_und3, exp_und0, exp_abt3;
        exp_und3 = 0; exp_und0 = 0; exp_abt3 = 0;
        und_cnt[0] = 0; und_cnt[1] = 0; abt_cnt[0] = 0; abt_cnt[1] = 0;
        reset = 1'b1;
        sclk  = 2'b01;
        ss_n  = 2'b11;
        mosi  = 2'b00;
        dvtx  = 2'b00;
        din[0] = '0;
        din[1] = '0;
        tick(3);
        // {0, miso, oe, ready, valid, underrun, abort, busy} after reset
        check("reset_status_mode3", 32'(status(0)), 32'h10);
        check("reset_dout_mode3",   32'(dout[0]),   32'h0);
        check("reset_status_mode0", 32'(status(1)), 32'h10);
        check("reset_dout_mode0",   32'(dout[1]),   32'h0);
        reset = 1'b0;
        tick(5);

        // Mode 3 single word
        preload(0, 8'hA5);
        ss_low(0);
        check("t1_busy", 32'(busy[0] & oe[0]), 32'd1);
        exp_q0.push_back(8'h3C);
        xfer(0, 1'b1, 1'b1, 8'h3C, 8, r);
        check("t1_miso_word", 32'(r), 32'hA5);
        ss_high(0);
        exp_und3 += 1;
        check("t1_underrun_count", 32'(und_cnt[0]), 32'(exp_und3));
        check("t1_idle", 32'(busy[0] | oe[0] | miso[0]), 32'd0);

        // Mode 0 single word, first bit present before the first leading edge
        preload(1, 8'hA5);
        ss_low(1);
        check("t2_first_bit_pre_lead", 32'(miso[1]), 32'd1);
        exp_q1.push_back(8'h3C);
        xfer(1, 1'b0, 1'b0, 8'h3C, 8, r);
        check("t2_miso_word", 32'(r), 32'hA5);
        ss_high(1);
        exp_und0 += 1;
        check("t2_underrun_count", 32'(und_cnt[1]), 32'(exp_und0));

        // Mode 3 back-to-back with refill on ready
        preload(0, 8'h11);
        fork
            preload(0, 8'h22);
            begin
                ss_low(0);
                exp_q0.push_back(8'h81);
                xfer(0, 1'b1, 1'b1, 8'h81, 8, r);
                check("t3_miso_word0", 32'(r), 32'h11);
                exp_q0.push_back(8'h42);
                xfer(0, 1'b1, 1'b1, 8'h42, 8, r);
                check("t3_miso_word1", 32'(r), 32'h22);
                ss_high(0);
            end
        join
        exp_und3 += 1;
        check("t3_underrun_count", 32'(und_cnt[0]), 32'(exp_und3));

        // Underrun at frame start: MISO all zeros, RX intact
        ss_low(0);
        exp_q0.push_back(8'h5A);
        xfer(0, 1'b1, 1'b1, 8'h5A, 8, r);
        check("t4_miso_zero", 32'(r), 32'h00);
        ss_high(0);
        exp_und3 += 2;
        check("t4_underrun_count", 32'(und_cnt[0]), 32'(exp_und3));

        // Abort after 5 SCLKs
        ss_low(0);
        xfer(0, 1'b1, 1'b1, 8'hFF, 5, r);
        ss_high(0);
        exp_und3 += 1;
        exp_abt3 += 1;
        check("t5_abort_count", 32'(abt_cnt[0]), 32'(exp_abt3));
        check("t5_underrun_count", 32'(und_cnt[0]), 32'(exp_und3));
        check("t5_dout_unchanged", 32'(dout[0]), 32'h5A);
        check("t5_oe_released", 32'(oe[0] | miso[0]), 32'd0);
        check("t5_no_pending", 32'(exp_q0.size()), 32'd0);

        // Reset mid-word (bit 3), then a clean frame
        ss_low(0);
        exp_und3 += 1;
        xfer(0, 1'b1, 1'b1, 8'h0F, 3, r);
        ss_n[0] = 1'b1;
        reset   = 1'b1;
        tick(1);
        check("t6_reset_status", 32'(status(0)), 32'h10);
        check("t6_reset_dout",   32'(dout[0]),   32'h0);
        reset = 1'b0;
        tick(5);
        preload(0, 8'hE7);
        ss_low(0);
        exp_q0.push_back(8'h96);
        xfer(0, 1'b1, 1'b1, 8'h96, 8, r);
        check("t6_miso_word", 32'(r), 32'hE7);
        ss_high(0);
        exp_und3 += 1;
        check("t6_underrun_count", 32'(und_cnt[0]), 32'(exp_und3));
        check("t6_abort_count", 32'(abt_cnt[0]), 32'(exp_abt3));
        check("t6_mode0_abort_count", 32'(abt_cnt[1]), 32'd0);

        tick(5);
        check("final_queue_mode3", 32'(exp_q0.size()), 32'd0);
        check("final_queue_mode0", 32'(exp_q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
